fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decoder.
- Owns the PC and runs a single-outstanding request/ready handshake to instruction memory.
- Presents the fetched instruction word with its PC and a valid flag to the decoder.
- Honours stall from hazard logic and redirect (taken branch/jump) from a later stage; bubbles are filled with NOP_INSTR so the decoder produces no memory or register access.

Parameters:
- RESET_PC, 32'h00001000, first fetch address after reset.
- NOP_INSTR, 32'h00000000, word driven on if_instruction when if_valid=0; its opcode must decode to no memory or register access.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; word aligned, equal to pc.
- imem_ready  in  1  response valid for the current imem_addr this cycle; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- stall  in  1  hold the IF/ID register.
- redirect_valid  in  1  one-cycle pulse carrying a new fetch target.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- if_valid  out  1  IF/ID holds a real instruction.
- if_instruction  out  32  instruction to the decoder.
- if_pc  out  32  address of if_instruction.
- if_pc_plus4  out  32  if_pc+4, registered.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, tgt=0, buf=0.
  - if_valid=0, if_instruction=NOP_INSTR, if_pc=0, if_pc_plus4=0.
  - imem_req=0.
- Outputs:
  - imem_req = (state==FETCH || state==DISCARD).
  - imem_addr = pc.
  - Once imem_req=1, imem_addr stays stable until imem_ready.
- accept = !stall || !if_valid.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFFFFFC wraps to 0.
- IDLE: go to FETCH next cycle; a redirect seen in IDLE loads pc=redirect_pc.
- FETCH:
  - ready & !redirect & accept: IF/ID loads {1, rdata, pc, pc+4}; pc+=4; stay in FETCH. Back-to-back, one instruction per cycle with zero-wait memory.
  - ready & !redirect & !accept: buf<=rdata; pc+=4; go to HOLD (req low, buffered instruction's pc = pc-4).
  - ready & redirect: drop rdata; pc<=redirect_pc; stay in FETCH.
  - !ready & redirect: tgt<=redirect_pc; go to DISCARD.
  - !ready & !redirect: hold.
- DISCARD:
  - A new redirect overwrites tgt.
  - On ready: drop rdata; pc<=(redirect ? redirect_pc : tgt); go to FETCH.
- HOLD:
  - accept & !redirect: IF/ID loads {1, buf, pc-4, pc}; go to FETCH.
  - redirect: drop buf; pc<=redirect_pc; go to FETCH.
- IF/ID update when not loading:
  - accept → if_valid<=0, if_instruction<=NOP_INSTR, if_pc and if_pc_plus4 held.
  - !accept → all held.
- Redirect flushes IF/ID in the same edge: if_valid<=0, if_instruction<=NOP_INSTR. Redirect dominates stall and any same-cycle load.
- Latency: instruction appears on if_* on the clock edge following imem_ready=1.
- Only one request outstanding at a time. No instruction is ever duplicated or lost except those squashed by a redirect.
- Reset mid-transaction abandons the request. The memory model must tolerate imem_req dropping before ready.

Test Plan:
- Reset release, zero-wait memory returning addr-derived data → imem_addr 0x1000, 0x1004, 0x1008 on consecutive cycles; if_valid rises 2 cycles after reset release; if_pc tracks each address one edge later.
- Memory with 3-cycle latency → imem_addr held 3 cycles; if_valid pulses one cycle per fetch; NOP_INSTR on if_instruction between instructions.
- stall=1 for 4 cycles while a fetch completes → IF/ID frozen; state HOLD, imem_req=0; on release, buffered word at if_pc=previous+4 loads with no gap or duplicate.
- redirect_valid with redirect_pc=0x2003 while a request is pending (latency 2) → data for the old address dropped; next imem_addr=0x2000; if_valid=0 in the cycle after redirect.
- Redirect and imem_ready in the same cycle, with stall=1 → IF/ID flushed (if_valid=0 despite stall); next imem_addr=redirect target.
- PC at 0xFFFFFFFC, zero-wait memory → next imem_addr=0x00000000; if_pc_plus4 of the last instruction=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, runs a single-outstanding
// request/ready handshake to instruction memory and feeds the decoder.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic [31:0] r_buf;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_plus4;

    logic        w_accept;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_minus4;

    assign w_accept      = !stall || !r_if_valid;
    assign w_redirect_pc = redirect_pc & ~32'h3;
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_pc_minus4   = r_pc - 32'd4;

    assign imem_req       = (r_state == S_FETCH) || (r_state == S_DISCARD);
    assign imem_addr      = r_pc;
    assign if_valid       = r_if_valid;
    assign if_instruction = r_if_instr;
    assign if_pc          = r_if_pc;
    assign if_pc_plus4    = r_if_pc_plus4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_tgt         <= 32'd0;
            r_buf         <= 32'd0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= NOP_INSTR;
            r_if_pc       <= 32'd0;
            r_if_pc_plus4 <= 32'd0;
        end else begin
            // Bubble by default when the decoder takes the slot or a redirect squashes it;
            // a load below overrides this, but the redirect paths never load.
            if (w_accept || redirect_valid) begin
                r_if_valid <= 1'b0;
                r_if_instr <= NOP_INSTR;
            end
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    if (redirect_valid)
                        r_pc <= w_redirect_pc;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        if (redirect_valid) begin
                            r_pc <= w_redirect_pc;
                        end else begin
                            r_pc <= w_pc_plus4;
                            if (w_accept) begin
                                r_if_valid    <= 1'b1;
                                r_if_instr    <= imem_rdata;
                                r_if_pc       <= r_pc;
                                r_if_pc_plus4 <= w_pc_plus4;
                            end else begin
                                r_buf   <= imem_rdata;
                                r_state <= S_HOLD;
                            end
                        end
                    end else if (redirect_valid) begin
                        // Request still in flight: finish it, then jump to the target.
                        r_tgt   <= w_redirect_pc;
                        r_state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (redirect_valid)
                        r_tgt <= w_redirect_pc;
                    if (imem_ready) begin
                        r_pc    <= redirect_valid ? w_redirect_pc : r_tgt;
                        r_state <= S_FETCH;
                    end
                end
                S_HOLD: begin
                    // Buffered word belongs to pc-4 because pc already advanced.
                    if (redirect_valid) begin
                        r_pc    <= w_redirect_pc;
                        r_state <= S_FETCH;
                    end else if (w_accept) begin
                        r_if_valid    <= 1'b1;
                        r_if_instr    <= r_buf;
                        r_if_pc       <= w_pc_minus4;
                        r_if_pc_plus4 <= r_pc;
                        r_state       <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory, stall/redirect stimulus, and a monitor
// checking the consumed instruction stream against a program-order scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_1000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory contents: address-derived, never equal to NOP since addresses are word aligned.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus-side state.
    int          lat;
    logic        drv_stall;
    int          redir_mode;   // 0 none, 1 now, 2 when request pending, 3 with ready (forces stall)
    logic [31:0] drv_target;
    int          wait_cnt;
    logic        last_req, last_ready;
    logic [31:0] last_addr;
    logic [31:0] redir_q[$];

    task automatic tick();
        @(negedge clk);
        if (last_req && !last_ready && imem_req && imem_addr == last_addr)
            wait_cnt++;
        else
            wait_cnt = 0;
        imem_ready = imem_req && (wait_cnt >= lat);
        imem_rdata = imem_ready ? mem_word(imem_addr) : 32'($urandom);
        stall          = drv_stall;
        redirect_valid = 1'b0;
        redirect_pc    = 32'($urandom);
        if (redir_mode == 1 || (redir_mode == 2 && imem_req && !imem_ready) ||
            (redir_mode == 3 && imem_ready)) begin
            redirect_valid = 1'b1;
            redirect_pc    = drv_target;
            redir_q.push_back(drv_target & ~32'h3);
            if (redir_mode == 3)
                stall = 1'b1;
            redir_mode = 0;
        end
        last_req   = imem_req;
        last_ready = imem_ready;
        last_addr  = imem_addr;
    endtask

    // Monitor: an instruction is consumed by the decoder on an edge where it was valid,
    // not stalled and not squashed by a redirect; consumed PCs must follow program order.
    logic        m_armed = 1'b0;
    logic        m_pv, m_preq;
    logic [31:0] m_pi, m_pp, m_pp4, m_pa;
    logic [31:0] exp_pc = RESET_PC;
    int          n_consumed = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_armed && !reset) begin
                if (redirect_valid) begin
                    check("flush_on_redirect", 32'(if_valid), 32'd0);
                    if (redir_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL redirect_queue: got empty expected target at %0t", $time);
                    end else begin
                        exp_pc = redir_q.pop_front();
                    end
                end else if (m_pv && !stall) begin
                    check("stream_pc", m_pp, exp_pc);
                    check("stream_instr", m_pi, mem_word(exp_pc));
                    check("stream_pc_plus4", m_pp4, exp_pc + 32'd4);
                    $display("txn %0d pc=%h instr=%h", n_consumed, m_pp, m_pi);
                    exp_pc = exp_pc + 32'd4;
                    n_consumed++;
                end else if (m_pv && stall) begin
                    check("stall_hold_valid", 32'(if_valid), 32'd1);
                    check("stall_hold_pc", if_pc, m_pp);
                    check("stall_hold_instr", if_instruction, m_pi);
                end
                if (m_preq && !imem_ready) begin
                    check("req_held", 32'(imem_req), 32'd1);
                    check("addr_stable", imem_addr, m_pa);
                end
                if (!if_valid)
                    check("nop_when_invalid", if_instruction, NOP_INSTR);
            end
            m_pv    = if_valid;
            m_pi    = if_instruction;
            m_pp    = if_pc;
            m_pp4   = if_pc_plus4;
            m_pa    = imem_addr;
            m_preq  = imem_req;
            m_armed = !reset;
        end
    end

    logic [31:0] hold_pc;
    logic [31:0] old_addr;

    initial begin
        reset = 1'b0;
        imem_ready = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        lat = 0; drv_stall = 1'b0; redir_mode = 0; drv_target = 32'd0;
        wait_cnt = 0; last_req = 1'b0; last_ready = 1'b0; last_addr = 32'd0;
        #2 reset = 1'b1;
        tick();
        tick();
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instruction, NOP_INSTR);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_pc_plus4", if_pc_plus4, 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        reset = 1'b0;

        // Zero-wait start-up sequence.
        tick();
        check("boot_req", 32'(imem_req), 32'd1);
        check("boot_addr0", imem_addr, 32'h1000);
        check("boot_valid_low", 32'(if_valid), 32'd0);
        tick();
        check("boot_valid_high", 32'(if_valid), 32'd1);
        check("boot_if_pc0", if_pc, 32'h1000);
        check("boot_pc_plus4", if_pc_plus4, 32'h1004);
        check("boot_addr1", imem_addr, 32'h1004);
        tick();
        check("boot_if_pc1", if_pc, 32'h1004);
        check("boot_addr2", imem_addr, 32'h1008);

        // Slow memory.
        lat = 2;
        repeat (20) tick();

        // Stall while a fetch completes.
        lat = 0;
        for (int i = 0; i < 10 && !(if_valid && imem_req); i++) tick();
        drv_stall = 1'b1;
        tick();
        tick();
        check("stall_req_low", 32'(imem_req), 32'd0);
        check("stall_valid_kept", 32'(if_valid), 32'd1);
        hold_pc = if_pc;
        tick();
        tick();
        drv_stall = 1'b0;
        tick();
        tick();
        check("unstall_next_pc", if_pc, hold_pc + 32'd4);
        check("unstall_valid", 32'(if_valid), 32'd1);

        // Redirect while a request is pending.
        lat = 2;
        tick();
        drv_target = 32'h0000_2003;
        redir_mode = 2;
        for (int i = 0; i < 10 && redir_mode != 0; i++) tick();
        check("pending_redirect_issued", 32'(redir_mode), 32'd0);
        old_addr = last_addr;
        tick();
        check("pending_redirect_flush", 32'(if_valid), 32'd0);
        for (int i = 0; i < 10 && imem_addr == old_addr; i++) tick();
        check("pending_redirect_addr", imem_addr, 32'h0000_2000);

        // Redirect coinciding with ready while stalled.
        lat = 0;
        for (int i = 0; i < 10 && !(if_valid && imem_req); i++) tick();
        drv_target = 32'h0000_3000;
        redir_mode = 3;
        for (int i = 0; i < 10 && redir_mode != 0; i++) tick();
        check("ready_redirect_issued", 32'(redir_mode), 32'd0);
        tick();
        check("ready_redirect_flush", 32'(if_valid), 32'd0);
        check("ready_redirect_addr", imem_addr, 32'h0000_3000);

        // PC wrap at the top of the address space.
        drv_target = 32'hFFFF_FFF8;
        redir_mode = 1;
        tick();
        for (int i = 0; i < 10 && imem_addr != 32'hFFFF_FFFC; i++) tick();
        tick();
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", if_pc_plus4, 32'h0000_0000);

        // Randomised mix of latency, stall and redirects.
        for (int i = 0; i < 1500; i++) begin
            if (i % 16 == 0) lat = $urandom_range(0, 3);
            drv_stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) begin
                drv_target = 32'($urandom);
                redir_mode = 1;
            end
            tick();
        end
        drv_stall = 1'b0;
        lat = 0;
        repeat (5) tick();

        check("liveness", 32'(n_consumed > 150), 32'd1);
        check("redirects_drained", 32'(redir_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
